// File: rtl/tl_rx_fc_pkg.sv
// Shared encodings for the TL RX flow-control initialisation tracker:
// FSM states, FC type codes and FC DLLP kind codes.
package tl_rx_fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT1 = 2'd1,
    ST_INIT2 = 2'd2,
    ST_DONE  = 2'd3
  } fc_state_e;

  localparam logic [1:0] FC_TYPE_P    = 2'b00;
  localparam logic [1:0] FC_TYPE_NP   = 2'b01;
  localparam logic [1:0] FC_TYPE_CPL  = 2'b10;
  localparam logic [1:0] FC_TYPE_RSVD = 2'b11;

  localparam logic [1:0] KIND_INITFC1 = 2'b00;
  localparam logic [1:0] KIND_INITFC2 = 2'b01;
  localparam logic [1:0] KIND_UPDATEFC = 2'b10;
  localparam logic [1:0] KIND_RSVD    = 2'b11;

endpackage

// File: rtl/tl_rx_fc_type_slice.sv
// Storage for one FC type: a recorded flag plus the first advertised
// header/data credits and scales. Once recorded, the values are frozen until clear.
module tl_rx_fc_type_slice #(
  parameter int HDR_W      = 12,
  parameter int DATA_W     = 16,
  parameter int DLL_HDR_W  = 12,
  parameter int DLL_DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DLL_HDR_W-1:0]  dll_hdr_creds,
  input  logic [DLL_DATA_W-1:0] dll_data_creds,
  input  logic [1:0]            dll_hdr_scale,
  input  logic [1:0]            dll_data_scale,
  output logic                  recorded,
  output logic [HDR_W-1:0]      hdr_creds,
  output logic [DATA_W-1:0]     data_creds,
  output logic [1:0]            hdr_scale,
  output logic [1:0]            data_scale
);

  logic [HDR_W-1:0]  hdr_fit_s;
  logic [DATA_W-1:0] data_fit_s;
  logic              recorded_r;
  logic [HDR_W-1:0]  hdr_creds_r;
  logic [DATA_W-1:0] data_creds_r;
  logic [1:0]        hdr_scale_r;
  logic [1:0]        data_scale_r;

  // DLL fields are truncated or zero-extended to the storage width
  if (HDR_W <= DLL_HDR_W) begin : g_hdr_trunc
    assign hdr_fit_s = dll_hdr_creds[HDR_W-1:0];
  end else begin : g_hdr_ext
    assign hdr_fit_s = {{(HDR_W-DLL_HDR_W){1'b0}}, dll_hdr_creds};
  end

  if (DATA_W <= DLL_DATA_W) begin : g_data_trunc
    assign data_fit_s = dll_data_creds[DATA_W-1:0];
  end else begin : g_data_ext
    assign data_fit_s = {{(DATA_W-DLL_DATA_W){1'b0}}, dll_data_creds};
  end

  // Capture-once storage; clear has priority over load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      recorded_r   <= 1'b0;
      hdr_creds_r  <= {HDR_W{1'b0}};
      data_creds_r <= {DATA_W{1'b0}};
      hdr_scale_r  <= 2'b00;
      data_scale_r <= 2'b00;
    end else if (clear) begin
      recorded_r   <= 1'b0;
      hdr_creds_r  <= {HDR_W{1'b0}};
      data_creds_r <= {DATA_W{1'b0}};
      hdr_scale_r  <= 2'b00;
      data_scale_r <= 2'b00;
    end else if (load && !recorded_r) begin
      recorded_r   <= 1'b1;
      hdr_creds_r  <= hdr_fit_s;
      data_creds_r <= data_fit_s;
      hdr_scale_r  <= dll_hdr_scale;
      data_scale_r <= dll_data_scale;
    end
  end

  assign recorded   = recorded_r;
  assign hdr_creds  = hdr_creds_r;
  assign data_creds = data_creds_r;
  assign hdr_scale  = hdr_scale_r;
  assign data_scale = data_scale_r;

endmodule

// File: rtl/tl_rx_fc_init_capture.sv
// RX flow-control init tracker: FC_INIT1 -> FC_INIT2 -> DONE sequencing,
// per-type credit capture, checker feed mux and sticky protocol error.
module tl_rx_fc_init_capture
  import tl_rx_fc_pkg::*;
#(
  parameter int FC_DATA_CREDS_WIDTH  = 16,
  parameter int FC_HDR_CREDS_WIDTH   = 12,
  parameter int DLL_DATA_CREDS_WIDTH = 16,
  parameter int DLL_HDR_CREDS_WIDTH  = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            dll_link_up,
  input  logic                            dll_valid,
  input  logic [1:0]                      dll_dllp_kind,
  input  logic [1:0]                      dll_fc_type,
  input  logic [DLL_HDR_CREDS_WIDTH-1:0]  dll_hdr_creds,
  input  logic [DLL_DATA_CREDS_WIDTH-1:0] dll_data_creds,
  input  logic [1:0]                      dll_hdr_scale,
  input  logic [1:0]                      dll_data_scale,
  input  logic                            flow_control_error,
  output logic                            flow_control_en,
  output logic [FC_HDR_CREDS_WIDTH-1:0]   hdr_creds_reg,
  output logic [FC_DATA_CREDS_WIDTH-1:0]  data_creds_reg,
  output logic [1:0]                      hdr_scale_reg,
  output logic [1:0]                      data_scale_reg,
  output logic [2:0]                      fc_recorded,
  output logic                            fc_init1_done,
  output logic                            fc_init_done,
  output logic                            fc_error_sticky
);

  fc_state_e state_r, state_next_s;
  logic      init1_done_r, init_done_r, error_sticky_r;

  logic [2:0] slice_rec_s;
  logic [FC_HDR_CREDS_WIDTH-1:0]  slice_hdr_s   [3];
  logic [FC_DATA_CREDS_WIDTH-1:0] slice_data_s  [3];
  logic [1:0]                     slice_hscl_s  [3];
  logic [1:0]                     slice_dscl_s  [3];

  logic       type_ok_s, kind_ok_s, init_kind_s, advance_kind_s;
  logic       type_recorded_s, record_s, advance_done_s, clear_s;
  logic [2:0] load_s, recorded_next_s;

  assign type_ok_s      = (dll_fc_type != FC_TYPE_RSVD);
  assign kind_ok_s      = (dll_dllp_kind != KIND_RSVD);
  assign init_kind_s    = (dll_dllp_kind == KIND_INITFC1) || (dll_dllp_kind == KIND_INITFC2);
  assign advance_kind_s = (dll_dllp_kind == KIND_INITFC2) || (dll_dllp_kind == KIND_UPDATEFC);
  assign clear_s        = ~dll_link_up;

  // Select the stored slice addressed by the presented FC type
  always_comb begin
    type_recorded_s = 1'b0;
    hdr_creds_reg   = {FC_HDR_CREDS_WIDTH{1'b0}};
    data_creds_reg  = {FC_DATA_CREDS_WIDTH{1'b0}};
    hdr_scale_reg   = 2'b00;
    data_scale_reg  = 2'b00;
    case (dll_fc_type)
      FC_TYPE_P, FC_TYPE_NP, FC_TYPE_CPL: begin
        type_recorded_s = slice_rec_s[dll_fc_type];
        hdr_creds_reg   = slice_hdr_s[dll_fc_type];
        data_creds_reg  = slice_data_s[dll_fc_type];
        hdr_scale_reg   = slice_hscl_s[dll_fc_type];
        data_scale_reg  = slice_dscl_s[dll_fc_type];
      end
      default: begin
        type_recorded_s = 1'b0;
      end
    endcase
  end

  assign flow_control_en = dll_valid & dll_link_up & type_ok_s & kind_ok_s & type_recorded_s;

  // Only a clean init DLLP of a not-yet-recorded type is captured
  assign record_s = ((state_r == ST_INIT1) || (state_r == ST_INIT2)) & dll_link_up & dll_valid &
                    init_kind_s & type_ok_s & ~type_recorded_s & ~flow_control_error;

  assign load_s = {record_s & (dll_fc_type == FC_TYPE_CPL),
                   record_s & (dll_fc_type == FC_TYPE_NP),
                   record_s & (dll_fc_type == FC_TYPE_P)};
  assign recorded_next_s = slice_rec_s | load_s;

  assign advance_done_s = dll_valid & advance_kind_s & type_ok_s & type_recorded_s &
                          ~flow_control_error & ~error_sticky_r;

  for (genvar i = 0; i < 3; i++) begin : g_slice
    tl_rx_fc_type_slice #(
      .HDR_W      (FC_HDR_CREDS_WIDTH),
      .DATA_W     (FC_DATA_CREDS_WIDTH),
      .DLL_HDR_W  (DLL_HDR_CREDS_WIDTH),
      .DLL_DATA_W (DLL_DATA_CREDS_WIDTH)
    ) u_slice (
      .clk            (clk),
      .rst            (rst),
      .load           (load_s[i]),
      .clear          (clear_s),
      .dll_hdr_creds  (dll_hdr_creds),
      .dll_data_creds (dll_data_creds),
      .dll_hdr_scale  (dll_hdr_scale),
      .dll_data_scale (dll_data_scale),
      .recorded       (slice_rec_s[i]),
      .hdr_creds      (slice_hdr_s[i]),
      .data_creds     (slice_data_s[i]),
      .hdr_scale      (slice_hscl_s[i]),
      .data_scale     (slice_dscl_s[i])
    );
  end

  // Next-state logic; link-down overrides every state
  always_comb begin
    state_next_s = state_r;
    if (!dll_link_up) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_next_s = ST_INIT1;
        ST_INIT1: state_next_s = (recorded_next_s == 3'b111) ? ST_INIT2 : ST_INIT1;
        ST_INIT2: state_next_s = advance_done_s ? ST_DONE : ST_INIT2;
        ST_DONE:  state_next_s = ST_DONE;
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  // State register with status flags registered alongside it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      init1_done_r <= 1'b0;
      init_done_r  <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      init1_done_r <= (state_next_s == ST_INIT2) || (state_next_s == ST_DONE);
      init_done_r  <= (state_next_s == ST_DONE);
    end
  end

  // Sticky protocol error, cleared only by reset or link-down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_sticky_r <= 1'b0;
    end else if (!dll_link_up) begin
      error_sticky_r <= 1'b0;
    end else if (flow_control_en && flow_control_error) begin
      error_sticky_r <= 1'b1;
    end
  end

  assign fc_recorded     = slice_rec_s;
  assign fc_init1_done   = init1_done_r;
  assign fc_init_done    = init_done_r;
  assign fc_error_sticky = error_sticky_r;

endmodule

// File: tb/tb_tl_rx_fc_init_capture.sv
// Table-driven self-checking bench for tl_rx_fc_init_capture with a
// scoreboard queue for combinational and post-edge expectations.
module tb_tl_rx_fc_init_capture;

  localparam logic [1:0] K1 = 2'b00, K2 = 2'b01, KU = 2'b10, KR = 2'b11;
  localparam logic [1:0] TP = 2'b00, TN = 2'b01, TC = 2'b10, TR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        dll_link_up, dll_valid, flow_control_error;
  logic [1:0]  dll_dllp_kind, dll_fc_type, dll_hdr_scale, dll_data_scale;
  logic [11:0] dll_hdr_creds;
  logic [15:0] dll_data_creds;
  logic        flow_control_en;
  logic [11:0] hdr_creds_reg;
  logic [15:0] data_creds_reg;
  logic [1:0]  hdr_scale_reg, data_scale_reg;
  logic [2:0]  fc_recorded;
  logic        fc_init1_done, fc_init_done, fc_error_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        lu, v;
    logic [1:0]  k, t;
    logic [11:0] h;
    logic [15:0] d;
    logic [1:0]  hs, ds;
    logic        er;
    logic        x_en;
    logic [11:0] x_h;
    logic [15:0] x_d;
    logic [1:0]  x_hs, x_ds;
    logic [2:0]  x_rec;
    logic        x_i1, x_done, x_st;
  } vec_t;

  vec_t tbl[$];
  vec_t comb_q[$];
  vec_t reg_q[$];

  tl_rx_fc_init_capture dut (
    .clk                (clk),
    .rst                (rst),
    .dll_link_up        (dll_link_up),
    .dll_valid          (dll_valid),
    .dll_dllp_kind      (dll_dllp_kind),
    .dll_fc_type        (dll_fc_type),
    .dll_hdr_creds      (dll_hdr_creds),
    .dll_data_creds     (dll_data_creds),
    .dll_hdr_scale      (dll_hdr_scale),
    .dll_data_scale     (dll_data_scale),
    .flow_control_error (flow_control_error),
    .flow_control_en    (flow_control_en),
    .hdr_creds_reg      (hdr_creds_reg),
    .data_creds_reg     (data_creds_reg),
    .hdr_scale_reg      (hdr_scale_reg),
    .data_scale_reg     (data_scale_reg),
    .fc_recorded        (fc_recorded),
    .fc_init1_done      (fc_init1_done),
    .fc_init_done       (fc_init_done),
    .fc_error_sticky    (fc_error_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic lu, input logic v, input logic [1:0] k, input logic [1:0] t,
                              input int h, input int d, input logic [1:0] hs, input logic [1:0] ds,
                              input logic er, input logic x_en, input int x_h, input int x_d,
                              input logic [1:0] x_hs, input logic [1:0] x_ds, input logic [2:0] x_rec,
                              input logic x_i1, input logic x_done, input logic x_st);
    vec_t r;
    r.lu = lu; r.v = v; r.k = k; r.t = t;
    r.h = 12'(h); r.d = 16'(d); r.hs = hs; r.ds = ds; r.er = er;
    r.x_en = x_en; r.x_h = 12'(x_h); r.x_d = 16'(x_d); r.x_hs = x_hs; r.x_ds = x_ds;
    r.x_rec = x_rec; r.x_i1 = x_i1; r.x_done = x_done; r.x_st = x_st;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t e);
    dll_link_up        = e.lu;
    dll_valid          = e.v;
    dll_dllp_kind      = e.k;
    dll_fc_type        = e.t;
    dll_hdr_creds      = e.h;
    dll_data_creds     = e.d;
    dll_hdr_scale      = e.hs;
    dll_data_scale     = e.ds;
    flow_control_error = e.er;
  endtask

  task automatic run_table(input string tag);
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      comb_q.push_back(tbl[i]);
      reg_q.push_back(tbl[i]);
      #2;
      if (comb_q.size() == 0) begin
        chk($sformatf("%s%0d.comb_q_empty", tag, i), 32'd1, 32'd0);
      end else begin
        e = comb_q.pop_front();
        chk($sformatf("%s%0d.en", tag, i), 32'(flow_control_en), 32'(e.x_en));
        chk($sformatf("%s%0d.hdr_reg", tag, i), 32'(hdr_creds_reg), 32'(e.x_h));
        chk($sformatf("%s%0d.data_reg", tag, i), 32'(data_creds_reg), 32'(e.x_d));
        chk($sformatf("%s%0d.scales", tag, i), 32'({hdr_scale_reg, data_scale_reg}), 32'({e.x_hs, e.x_ds}));
      end
      @(posedge clk);
      #1;
      if (reg_q.size() == 0) begin
        chk($sformatf("%s%0d.reg_q_empty", tag, i), 32'd1, 32'd0);
      end else begin
        e = reg_q.pop_front();
        chk($sformatf("%s%0d.recorded", tag, i), 32'(fc_recorded), 32'(e.x_rec));
        chk($sformatf("%s%0d.init1_done", tag, i), 32'(fc_init1_done), 32'(e.x_i1));
        chk($sformatf("%s%0d.init_done", tag, i), 32'(fc_init_done), 32'(e.x_done));
        chk($sformatf("%s%0d.sticky", tag, i), 32'(fc_error_sticky), 32'(e.x_st));
      end
    end
    tbl.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".en"}, 32'(flow_control_en), 32'd0);
    chk({tag, ".hdr_reg"}, 32'(hdr_creds_reg), 32'd0);
    chk({tag, ".data_reg"}, 32'(data_creds_reg), 32'd0);
    chk({tag, ".scales"}, 32'({hdr_scale_reg, data_scale_reg}), 32'd0);
    chk({tag, ".recorded"}, 32'(fc_recorded), 32'd0);
    chk({tag, ".init1_done"}, 32'(fc_init1_done), 32'd0);
    chk({tag, ".init_done"}, 32'(fc_init_done), 32'd0);
    chk({tag, ".sticky"}, 32'(fc_error_sticky), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(mk(1'b0, 1'b0, K1, TP, 0, 0, 2'd0, 2'd0, 1'b0, 1'b0, 0, 0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Clean bring-up, repeat P without overwrite, reserved type, DONE, link-down with valid
    tbl.push_back(mk(1, 0, K1, TP,     0,      0, 0, 0, 0,  0,     0,      0, 0, 0, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 1, K1, TP,    40,    200, 0, 0, 0,  0,     0,      0, 0, 0, 3'b001, 0, 0, 0));
    tbl.push_back(mk(1, 1, K1, TN,    20,    100, 1, 2, 0,  0,     0,      0, 0, 0, 3'b011, 0, 0, 0));
    tbl.push_back(mk(1, 1, K1, TC, 'hFFF, 'hFFFF, 3, 3, 0,  0,     0,      0, 0, 0, 3'b111, 1, 0, 0));
    tbl.push_back(mk(1, 1, K1, TP,    55,      9, 1, 1, 0,  1,    40,    200, 0, 0, 3'b111, 1, 0, 0));
    tbl.push_back(mk(1, 1, K1, TR,     1,      1, 0, 0, 0,  0,     0,      0, 0, 0, 3'b111, 1, 0, 0));
    tbl.push_back(mk(1, 1, K2, TN,     1,      1, 0, 0, 0,  1,    20,    100, 1, 2, 3'b111, 1, 1, 0));
    tbl.push_back(mk(1, 1, KU, TC,     0,      0, 0, 0, 0,  1, 'hFFF, 'hFFFF, 3, 3, 3'b111, 1, 1, 0));
    tbl.push_back(mk(1, 1, KU, TP,     0,      0, 0, 0, 0,  1,    40,    200, 0, 0, 3'b111, 1, 1, 0));
    tbl.push_back(mk(0, 1, K1, TP,    40,    200, 0, 0, 0,  0,    40,    200, 0, 0, 3'b000, 0, 0, 0));
    tbl.push_back(mk(0, 0, K1, TP,     0,      0, 0, 0, 0,  0,     0,      0, 0, 0, 3'b000, 0, 0, 0));
    run_table("seq");

    // Reserved kind/type, UpdateFC in INIT1, checker errors and sticky blocking DONE
    tbl.push_back(mk(1, 0, K1, TP,     0,      0, 0, 0, 0,  0,     0,      0, 0, 0, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 1, K1, TR,     5,      5, 1, 1, 0,  0,     0,      0, 0, 0, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 1, KR, TP,     5,      5, 1, 1, 0,  0,     0,      0, 0, 0, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 1, K1, TP,    10,     30, 2, 1, 0,  0,     0,      0, 0, 0, 3'b001, 0, 0, 0));
    tbl.push_back(mk(1, 1, KU, TP,     0,      0, 0, 0, 0,  1,    10,     30, 2, 1, 3'b001, 0, 0, 0));
    tbl.push_back(mk(1, 1, KR, TP,     0,      0, 0, 0, 0,  0,    10,     30, 2, 1, 3'b001, 0, 0, 0));
    tbl.push_back(mk(1, 1, K1, TN,     5,      6, 0, 0, 1,  0,     0,      0, 0, 0, 3'b001, 0, 0, 0));
    tbl.push_back(mk(1, 1, K1, TP,    10,     30, 2, 1, 1,  1,    10,     30, 2, 1, 3'b001, 0, 0, 1));
    tbl.push_back(mk(1, 1, K1, TN,     5,      6, 0, 0, 0,  0,     0,      0, 0, 0, 3'b011, 0, 0, 1));
    tbl.push_back(mk(1, 1, K1, TC,     7,      8, 1, 0, 0,  0,     0,      0, 0, 0, 3'b111, 1, 0, 1));
    tbl.push_back(mk(1, 1, K2, TP,     0,      0, 0, 0, 0,  1,    10,     30, 2, 1, 3'b111, 1, 0, 1));
    tbl.push_back(mk(1, 1, K2, TN,     0,      0, 0, 0, 0,  1,     5,      6, 0, 0, 3'b111, 1, 0, 1));
    run_table("err");

    // Asynchronous reset while in INIT2 with link still up
    @(negedge clk);
    dll_valid = 1'b0;
    flow_control_error = 1'b0;
    dll_fc_type = TP;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Restart from IDLE after reset release
    tbl.push_back(mk(1, 0, K1, TP,     0,      0, 0, 0, 0,  0,     0,      0, 0, 0, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 1, K1, TP,     3,      4, 1, 1, 0,  0,     0,      0, 0, 0, 3'b001, 0, 0, 0));
    tbl.push_back(mk(1, 1, KU, TP,     0,      0, 0, 0, 0,  1,     3,      4, 1, 1, 3'b001, 0, 0, 0));
    run_table("rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_rx_fc_init_capture.md
# tl_rx_fc_init_capture

Receive-side flow-control initialisation tracker for the TL RX write path. It consumes FC DLLP fields presented by the DLL, walks the FC_INIT1 → FC_INIT2 → done sequence, and records the first advertised header/data credits and scales for each FC type (P, NP, Cpl). It drives the stored values and the enable into the flow-control error checker for the DLLP currently presented. It takes that checker's error result back to gate recording and to hold a sticky protocol error.

## Interface
- FC_DATA_CREDS_WIDTH, 16, width of stored data credits
- FC_HDR_CREDS_WIDTH, 12, width of stored header credits
- DLL_DATA_CREDS_WIDTH, 16, width of DLL data-credit field
- DLL_HDR_CREDS_WIDTH, 12, width of DLL header-credit field

One clock; reset is asynchronous and active-high.

- clk  in  1  block clock
- rst  in  1  asynchronous active-high reset
- dll_link_up  in  1  DL_Up from DLL; low forces IDLE and clears records
- dll_valid  in  1  FC DLLP fields valid this cycle
- dll_dllp_kind  in  2  00 InitFC1, 01 InitFC2, 10 UpdateFC, 11 reserved
- dll_fc_type  in  2  00 P, 01 NP, 10 Cpl, 11 reserved
- dll_hdr_creds  in  DLL_HDR_CREDS_WIDTH  advertised header credits
- dll_data_creds  in  DLL_DATA_CREDS_WIDTH  advertised data credits
- dll_hdr_scale  in  2  header scale
- dll_data_scale  in  2  data scale
- flow_control_error  in  1  combinational result from the error checker, same cycle
- flow_control_en  out  1  valid DLLP whose type is already recorded
- hdr_creds_reg  out  FC_HDR_CREDS_WIDTH  stored header credits of dll_fc_type
- data_creds_reg  out  FC_DATA_CREDS_WIDTH  stored data credits of dll_fc_type
- hdr_scale_reg  out  2  stored header scale of dll_fc_type
- data_scale_reg  out  2  stored data scale of dll_fc_type
- fc_recorded  out  3  per-type recorded flags {Cpl,NP,P}
- fc_init1_done  out  1  state is INIT2 or DONE
- fc_init_done  out  1  state is DONE
- fc_error_sticky  out  1  latched protocol error

## Operation
- States: IDLE, INIT1, INIT2, DONE. Reset → IDLE; all registers and outputs are 0.
- Transitions:
  - IDLE → INIT1 when dll_link_up=1.
  - INIT1 → INIT2 on the edge at which the third type becomes recorded.
  - INIT2 → DONE on a valid InitFC2 or UpdateFC of any recorded type with flow_control_error=0.
  - Any state → IDLE when dll_link_up=0. Leaving for IDLE clears the fc_recorded flags, stored values and fc_error_sticky.
- Recording:
  - Applies in INIT1 or INIT2 when dll_valid=1, kind is InitFC1 or InitFC2, type is not 11, type is unrecorded, and flow_control_error=0.
  - On a record, the type's creds are truncated/zero-extended to the register widths, the scales are stored, and the type's flag is set.
  - Values are never overwritten once recorded.
- Checker feed:
  - flow_control_en = dll_valid & dll_link_up & (type≠11) & kind≠11 & fc_recorded[type].
  - The *_reg outputs are a combinational mux of the stored slices by dll_fc_type, and are 0 for type 11.
- Error:
  - fc_error_sticky sets on any cycle with flow_control_en=1 and flow_control_error=1.
  - It holds until reset or link-down.
  - While set, no state advance to DONE occurs. Recording of other unrecorded types still occurs.
- UpdateFC in INIT1 is ignored except for the check. Reserved kind or type is ignored entirely.

## Timing
- The *_reg outputs and flow_control_en are combinational from the current dll_* inputs and registered state (0 cycles). The checker result is sampled at the same edge.
- A record is visible on the *_reg outputs the cycle after capture. The first DLLP of a type therefore sees flow_control_en=0.
- fc_init1_done and fc_init_done are registered, 1 cycle after the qualifying DLLP.
- Simultaneous link-down and valid DLLP: link-down wins, nothing is recorded, and the sticky error does not set.
- Reset asserted mid-sequence: immediate return to IDLE with all outputs 0.

## Structure
- Shared package tl_rx_fc_pkg:
  - state encoding (IDLE=0, INIT1=1, INIT2=2, DONE=3)
  - FC type codes
  - DLLP kind codes
- Sub-module tl_rx_fc_type_slice: one recorded flag plus hdr/data creds and scales, with load and clear inputs. It is instantiated three times.
- The top level holds the FSM, the output mux and the sticky error.

## Test plan
- Link up, InitFC1 P(hdr 40, data 200, scales 0), then NP, then Cpl, no errors → fc_recorded=111 one cycle after Cpl, fc_init1_done=1, then InitFC2 P → fc_init_done=1 next cycle.
- Repeat InitFC1 P with hdr 40 → flow_control_en=1, hdr_creds_reg=40, data_creds_reg=200, stored values unchanged.
- Checker drives flow_control_error=1 on the first InitFC1 NP → NP not recorded, fc_recorded[1]=0; on a later repeated P with error=1 → fc_error_sticky=1 and InitFC2 does not reach DONE.
- In DONE, drop dll_link_up together with dll_valid=1 → next cycle state IDLE, fc_recorded=000, sticky=0, all *_reg 0.
- dll_fc_type=11 or dll_dllp_kind=11 with dll_valid=1 in INIT1 → flow_control_en=0, no record, no state change.
- Assert rst asynchronously in INIT2 → all outputs 0 immediately; after release and link up, the sequence restarts from INIT1.
